// File: rtl/tap_sequencer_if.sv
// Handshake/bus bundle between the tap sequencer and its delay line, MAC and output stage.
// With SYMMETRIC_FOLD_EN defined the bundle also carries mirror_count.
interface tap_sequencer_if #(
  parameter int NUM_TAPS = 64
);
  localparam int CNT_W = $clog2(NUM_TAPS);

  logic             in_valid;
  logic             in_ready;
  logic             phase_0;
  logic [CNT_W-1:0] current_count;
`ifdef SYMMETRIC_FOLD_EN
  logic [CNT_W-1:0] mirror_count;
`endif
  logic             acc_clear;
  logic             acc_en;
  logic             busy;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  in_valid,
    input  out_ready,
`ifdef SYMMETRIC_FOLD_EN
    output mirror_count,
`endif
    output in_ready,
    output phase_0,
    output current_count,
    output acc_clear,
    output acc_en,
    output busy,
    output out_valid
  );

  modport slave (
    output in_valid,
    output out_ready,
`ifdef SYMMETRIC_FOLD_EN
    input  mirror_count,
`endif
    input  in_ready,
    input  phase_0,
    input  current_count,
    input  acc_clear,
    input  acc_en,
    input  busy,
    input  out_valid
  );
endinterface

// File: rtl/tap_sequencer.sv
// Per-band delay-line read sequencer: sample handshake, tap scan, MAC drain, frame-done handshake.
// SYMMETRIC_FOLD_EN: half-length scan plus a registered mirror_count read index.
module tap_sequencer #(
  parameter int NUM_TAPS    = 64,
  parameter int MAC_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  tap_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(NUM_TAPS);
  localparam int DW    = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((MAC_LATENCY > 0) ? MAC_LATENCY - 1 : 0);
`ifdef SYMMETRIC_FOLD_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TAPS / 2 - 1);
  localparam logic [CNT_W-1:0] MIR_TOP  = CNT_W'(NUM_TAPS - 1);
`else
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TAPS - 1);
`endif

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [DW-1:0]    drain_q, drain_nxt;
  logic             clr_q, clr_nxt;
  logic             en_q, en_nxt;
  logic             ov_q, ov_nxt;
  logic             busy_q, busy_nxt;

  // Shift strobe coincides with the accepting edge; rst blocks the handshake.
  assign bus.in_ready      = (state == IDLE);
  assign bus.phase_0       = bus.in_valid & bus.in_ready & ~rst;
  assign bus.current_count = cnt_q;
  assign bus.acc_clear     = clr_q;
  assign bus.acc_en        = en_q;
  assign bus.out_valid     = ov_q;
  assign bus.busy          = busy_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    drain_nxt = drain_q;
    clr_nxt   = 1'b0;
    en_nxt    = 1'b0;
    ov_nxt    = ov_q;
    unique case (state)
      IDLE: if (bus.in_valid) begin
        state_nxt = SCAN;
        cnt_nxt   = '0;
        en_nxt    = 1'b1;
        clr_nxt   = 1'b1;
      end
      SCAN: if (cnt_q == CNT_LAST) begin
        cnt_nxt   = '0;
        drain_nxt = '0;
        if (MAC_LATENCY == 0) begin
          state_nxt = DONE;
          ov_nxt    = 1'b1;
        end else begin
          state_nxt = DRAIN;
        end
      end else begin
        cnt_nxt = cnt_q + 1'b1;
        en_nxt  = 1'b1;
      end
      DRAIN: if (drain_q == DRAIN_LAST) begin
        state_nxt = DONE;
        ov_nxt    = 1'b1;
      end else begin
        drain_nxt = drain_q + 1'b1;
      end
      DONE: if (bus.out_ready) begin
        state_nxt = IDLE;
        ov_nxt    = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt_q   <= cnt_nxt;
      drain_q <= drain_nxt;
      clr_q   <= clr_nxt;
      en_q    <= en_nxt;
      ov_q    <= ov_nxt;
      busy_q  <= busy_nxt;
    end
  end

`ifdef SYMMETRIC_FOLD_EN
  logic [CNT_W-1:0] mir_q;
  assign bus.mirror_count = mir_q;

  // Aligned with current_count; parked at 0 whenever the scan is not running.
  always_ff @(posedge clk) begin
    if (rst)                    mir_q <= '0;
    else if (state_nxt == SCAN) mir_q <= MIR_TOP - cnt_nxt;
    else                        mir_q <= '0;
  end
`endif
endmodule

// File: tb/tb_tap_sequencer.sv
// Scoreboard bench for tap_sequencer: each accepted sample queues its tap beats and result cycle.
module tb_tap_sequencer;
  localparam int NUM_TAPS    = 64;
  localparam int MAC_LATENCY = 2;
`ifdef SYMMETRIC_FOLD_EN
  localparam int SCAN_N = NUM_TAPS / 2;
`else
  localparam int SCAN_N = NUM_TAPS;
`endif
  localparam int PERIOD = SCAN_N + MAC_LATENCY + 2;

  typedef struct {
    int cnt;
    int clr;
    int mir;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  bit   stream;
  int   total = 0;
  int   bad   = 0;
  beat_t exp_q[$];
  int    done_q[$];

  tap_sequencer_if #(.NUM_TAPS(NUM_TAPS)) bus ();

  tap_sequencer #(.NUM_TAPS(NUM_TAPS), .MAC_LATENCY(MAC_LATENCY)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_ov(input int lim);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) chk("ov_timeout", 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"},  bus.in_ready, 1);
    chk({tag, "_p0"},   bus.phase_0, 0);
    chk({tag, "_en"},   bus.acc_en, 0);
    chk({tag, "_clr"},  bus.acc_clear, 0);
    chk({tag, "_ov"},   bus.out_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_cnt"},  bus.current_count, 0);
`ifdef SYMMETRIC_FOLD_EN
    chk({tag, "_mir"},  bus.mirror_count, 0);
`endif
  endtask

  // Monitor / scoreboard, sampling on the falling edge.
  initial begin
    int cyc = 0, last_p0 = 0, nbeats = 0;
    bit pv_ov = 0, pv_or = 0, pv_acc = 0, pv_rst = 1, in_frame = 0, last_strm = 0;
    bit held;
    beat_t b;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("p0_rst", bus.phase_0, 0);
        exp_q.delete();
        done_q.delete();
        in_frame  = 0;
        nbeats    = 0;
        last_strm = 0;
      end else begin
        held = pv_ov && !pv_or && !pv_rst;
        if (pv_acc) chk("idle_after", bus.in_ready, 1);
        if (held) chk("ov_hold", bus.out_valid, 1);
        if (bus.out_valid) chk("rdy_bp", bus.in_ready, 0);
        if (bus.out_valid && !held) begin
          if (done_q.size() == 0) chk("ov_unexp", 1, 0);
          else begin
            chk("ov_cyc", cyc, done_q.pop_front());
            chk("beats", nbeats, SCAN_N);
          end
        end
        if (bus.acc_en) begin
          nbeats++;
          if (exp_q.size() == 0) chk("acc_unexp", 1, 0);
          else begin
            b = exp_q.pop_front();
            chk("cnt", bus.current_count, b.cnt);
            chk("clr", bus.acc_clear, b.clr);
            chk("busy_scan", bus.busy, 1);
`ifdef SYMMETRIC_FOLD_EN
            chk("mir", bus.mirror_count, b.mir);
`endif
          end
        end else begin
          chk("cnt_idle", bus.current_count, 0);
          chk("clr_idle", bus.acc_clear, 0);
`ifdef SYMMETRIC_FOLD_EN
          chk("mir_idle", bus.mirror_count, 0);
`endif
        end
        if (bus.phase_0) begin
          chk("p0_mid", in_frame, 0);
          chk("busy_p0", bus.busy, 0);
          if (stream && last_strm) chk("p0_gap", cyc - last_p0, PERIOD);
          last_p0   = cyc;
          last_strm = stream;
          in_frame  = 1;
          nbeats    = 0;
          for (int i = 0; i < SCAN_N; i++) begin
            b.cnt = i;
            b.clr = (i == 0) ? 1 : 0;
            b.mir = NUM_TAPS - 1 - i;
            exp_q.push_back(b);
          end
          done_q.push_back(cyc + SCAN_N + MAC_LATENCY + 1);
        end
        if (bus.out_valid && bus.out_ready) in_frame = 0;
      end
      pv_ov  = bus.out_valid;
      pv_or  = bus.out_ready;
      pv_acc = bus.out_valid && bus.out_ready && !rst;
      pv_rst = rst;
    end
  end

  initial begin
    int n, k;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    stream = 1'b0;

    // Reset for two cycles, with in_valid raised during the second.
    @(posedge clk); #1 bus.in_valid = 1'b1;
    @(posedge clk); #1 rst = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst");

    // Single frame.
    @(posedge clk); #1 bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    wait_ov(300);
    repeat (3) @(negedge clk);

    // Result backpressure with a waiting sample.
    @(posedge clk); #1 bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    wait_ov(300);
    repeat (10) begin
      @(negedge clk);
      chk("bp_ov", bus.out_valid, 1);
      chk("bp_rdy", bus.in_ready, 0);
    end
    @(posedge clk); #1 bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle", bus.in_ready, 1);
    chk("bp_ov_clr", bus.out_valid, 0);

    // Streaming: back-to-back frames.
    @(posedge clk); #1 stream = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    n = 0;
    k = 0;
    while (n < 4 && k < 1000) begin
      @(negedge clk);
      k++;
      if (bus.phase_0) n++;
    end
    chk("stream_frames", n, 4);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    wait_ov(300);
    repeat (3) @(negedge clk);
    stream = 1'b0;

    // Reset in the middle of the scan.
    @(posedge clk); #1 bus.in_valid = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.acc_en && bus.current_count == 30) && k < 200);
    chk("mid_reach", bus.current_count, 30);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    chk("midrst_no_ov", n, 0);

    // Normal operation resumes after the aborted frame.
    @(posedge clk); #1 bus.in_valid = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    wait_ov(300);
    repeat (3) @(negedge clk);
    chk("final_idle", bus.in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
